// File: rtl/regfile_param.sv
// regfile_param -- parametrised 2-read / 1-write register bank for the
// decode stage. Entry INIT_IDX comes out of reset holding INIT_VAL; every
// other entry comes out holding 0. A sequenced sweep writes these values
// one entry per cycle after reset is released.
//
// Optional feature macro: REGFILE_WR_BYPASS_EN
//   defined   : write-first forwarding. A legal write shows up on a read
//               port with the same address in the same cycle.
//   undefined : read-before-write. The old contents are returned until
//               the edge that commits the write.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   we3      in   write enable
//   a3       in   write address   [ADDR_W]
//   wd3      in   write data      [DATA_W]
//   a1, a2   in   read addresses  [ADDR_W]
//   rd1, rd2 out  combinational read data [DATA_W]
//   busy     out  high while reset is held or the init sweep is running
//   wr_drop  out  registered 1-cycle pulse: a write request was discarded
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 32,
   parameter bit ZERO_REG = 1'b1,
   parameter int INIT_IDX = 5,
   parameter logic [31:0] INIT_VAL = 32'h000F_FFAF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we3,
   input  logic [ADDR_W-1:0] a3,
   input  logic [DATA_W-1:0] wd3,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              busy,
   output logic              wr_drop
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_W  = (ADDR_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] INIT_IDX_W = IDX_W'(INIT_IDX);
   localparam bit INIT_IDX_OK = (INIT_IDX >= 0) && (INIT_IDX < DEPTH);
   localparam logic [DATA_W-1:0] INIT_V = DATA_W'(INIT_VAL);

   typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               wr_drop_q, wr_drop_d;
   logic [DATA_W-1:0]  mem_q [DEPTH];

   logic               mem_we;
   logic [IDX_W-1:0]   mem_wa;
   logic [DATA_W-1:0]  mem_wd;
   logic               wr_legal;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_W);
   endfunction

   function automatic logic zero_hit(input logic [ADDR_W-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   // Read mux for one port. Out-of-range and zero-register addresses read 0,
   // and everything reads 0 until the sweep has finished so decode never
   // sees stale or uninitialised contents.
   function automatic logic [DATA_W-1:0] read_port(
      input logic [ADDR_W-1:0] a,
      input logic [DATA_W-1:0] entry,
      input logic              ready,
      input logic              fwd
   );
      if (!ready || !in_range(a) || zero_hit(a))
         return '0;
      else if (fwd && (a == a3))
         return wd3;
      else
         return entry;
   endfunction

   // A write commits only when not in reset, the sweep is over, and the
   // target is a real, writable entry.
   assign wr_legal = !reset && (state_q == READY) && we3 && in_range(a3) && !zero_hit(a3);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= INIT;
         idx_q     <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   // Storage has no reset; the sweep provides the initial contents.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem_q[mem_wa] <= mem_wd;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_drop_d = 1'b0;
      mem_we    = 1'b0;
      mem_wa    = idx_q;
      mem_wd    = '0;
      case (state_q)
         INIT: begin
            mem_we    = !reset;
            mem_wa    = idx_q;
            mem_wd    = (INIT_IDX_OK && (idx_q == INIT_IDX_W)) ? INIT_V : '0;
            wr_drop_d = we3;
            if (idx_q == LAST_IDX) begin
               state_d = READY;
               idx_d   = '0;
            end else begin
               idx_d   = idx_q + 1'b1;
            end
         end
         READY: begin
            mem_we    = wr_legal;
            mem_wa    = a3[IDX_W-1:0];
            mem_wd    = wd3;
            // Zero-register writes are silently ignored, only out-of-range
            // addresses are reported as dropped.
            wr_drop_d = we3 && !in_range(a3);
         end
         default: begin
            state_d = INIT;
            idx_d   = '0;
         end
      endcase
   end

   logic fwd;
`ifdef REGFILE_WR_BYPASS_EN
   assign fwd = wr_legal;
`else
   assign fwd = 1'b0;
`endif

   assign rd1     = read_port(a1, mem_q[a1[IDX_W-1:0]], state_q == READY, fwd);
   assign rd2     = read_port(a2, mem_q[a2[IDX_W-1:0]], state_q == READY, fwd);
   assign busy    = reset || (state_q != READY);
   assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed testbench for regfile_param: default 32-entry build plus a
// 16-entry build sharing the same stimulus.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        we3;
   logic [4:0]  a3, a1, a2;
   logic [31:0] wd3;
   logic [31:0] rd1, rd2, rd1_16, rd2_16;
   logic        busy, wr_drop, busy_16, wr_drop_16;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_param dut (
      .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3),
      .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2), .busy(busy), .wr_drop(wr_drop)
   );

   regfile_param #(.DEPTH(16), .ADDR_W(5)) dut16 (
      .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3),
      .a1(a1), .a2(a2), .rd1(rd1_16), .rd2(rd2_16), .busy(busy_16), .wr_drop(wr_drop_16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles with busy high after reset release; bounded.
   task automatic count_busy(input bit chk_rd, output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         if (chk_rd) begin
            a1 = 5'(n);
            a2 = 5'd5;
            #1;
            check("sweep_rd", rd1 | rd2, 32'h0);
         end
         n++;
         tick();
      end
   endtask

   logic [31:0] exp_bypass;
   int n;

   initial begin
      reset = 1'b1; we3 = 1'b0; a3 = '0; wd3 = '0; a1 = 5'd5; a2 = 5'd7;

      // 1: reset then sweep
      repeat (3) tick();
      check("reset_busy", {31'b0, busy}, 32'd1);
      check("reset_wr_drop", {31'b0, wr_drop}, 32'd0);
      reset = 1'b0;
      count_busy(1'b1, n);
      check("busy_len", n, 32'd32);
      a1 = 5'd5; a2 = 5'd7; #1;
      check("init_entry5", rd1, 32'h000FFFAF);
      check("entry7_zero", rd2, 32'h0);
      check("ready_wr_drop", {31'b0, wr_drop}, 32'd0);

      // 2: write 10, same-cycle and next-cycle reads
      we3 = 1'b1; a3 = 5'd10; wd3 = 32'hDEADBEEF; a1 = 5'd10; a2 = 5'd10; #1;
`ifdef REGFILE_WR_BYPASS_EN
      exp_bypass = 32'hDEADBEEF;
`else
      exp_bypass = 32'h0;
`endif
      check("same_cycle_rd1", rd1, exp_bypass);
      check("same_cycle_rd2", rd2, exp_bypass);
      tick();
      we3 = 1'b0; #1;
      check("next_cycle_rd1", rd1, 32'hDEADBEEF);
      check("next_cycle_rd2", rd2, 32'hDEADBEEF);
      check("legal_wr_drop", {31'b0, wr_drop}, 32'd0);

      // 3: zero register write
      we3 = 1'b1; a3 = 5'd0; wd3 = 32'h12345678; a1 = 5'd0; #1;
      check("zero_same_cycle", rd1, 32'h0);
      tick();
      we3 = 1'b0; #1;
      check("zero_rd", rd1, 32'h0);
      check("zero_wr_drop", {31'b0, wr_drop}, 32'd0);

      // 4: write during sweep is dropped
      reset = 1'b1; tick(); reset = 1'b0;
      repeat (4) tick();
      we3 = 1'b1; a3 = 5'd3; wd3 = 32'hFFFFFFFF;
      tick();
      we3 = 1'b0;
      check("sweep_drop_pulse", {31'b0, wr_drop}, 32'd1);
      tick();
      check("sweep_drop_end", {31'b0, wr_drop}, 32'd0);
      count_busy(1'b0, n);
      check("busy_len2", n, 32'd26);
      a1 = 5'd3; a2 = 5'd10; #1;
      check("dropped_entry3", rd1, 32'h0);
      check("swept_entry10", rd2, 32'h0);

      // 6: out-of-range write on the 16-entry build
      check("d16_ready", {31'b0, busy_16}, 32'd0);
      we3 = 1'b1; a3 = 5'd20; wd3 = 32'h11111111;
      tick();
      we3 = 1'b0;
      check("d16_drop_pulse", {31'b0, wr_drop_16}, 32'd1);
      check("d32_no_drop", {31'b0, wr_drop}, 32'd0);
      a1 = 5'd20; a2 = 5'd4; #1;
      check("d16_rd_oor", rd1_16, 32'h0);
      check("d16_entry4", rd2_16, 32'h0);
      tick();
      check("d16_drop_end", {31'b0, wr_drop_16}, 32'd0);

      // 5: reset mid-sweep restarts it
      we3 = 1'b1; a3 = 5'd20; wd3 = 32'hA5A5A5A5;
      tick();
      we3 = 1'b0; a1 = 5'd20; #1;
      check("pre_reset_entry20", rd1, 32'hA5A5A5A5);
      reset = 1'b1; tick(); reset = 1'b0;
      repeat (15) tick();
      check("mid_sweep_busy", {31'b0, busy}, 32'd1);
      reset = 1'b1; repeat (2) tick();
      check("mid_reset_busy", {31'b0, busy}, 32'd1);
      reset = 1'b0;
      count_busy(1'b0, n);
      check("busy_len3", n, 32'd32);
      a1 = 5'd5; a2 = 5'd20; #1;
      check("restart_entry5", rd1, 32'h000FFFAF);
      check("restart_entry20", rd2, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
